mem_arbiter: RTL and testbench

//  Two-port arbiter that shares the single synchronous memory port (mem) between

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the shared memory port and the arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int WORD_W = 36
);
    logic [ADDR_W-1:0] p0_addr;
    logic [WORD_W-1:0] p0_write_data;
    logic              p0_read;
    logic              p0_write;
    logic              p0_user;
    logic [WORD_W-1:0] p0_read_data;
    logic              p0_ack;
    logic              p0_nxm;

    logic [ADDR_W-1:0] p1_addr;
    logic [WORD_W-1:0] p1_write_data;
    logic              p1_read;
    logic              p1_write;
    logic              p1_user;
    logic [WORD_W-1:0] p1_read_data;
    logic              p1_ack;
    logic              p1_nxm;

    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic              mem_user;
    logic [WORD_W-1:0] mem_read_data;
    logic              mem_ack;

    modport slave (
        input  p0_addr, p0_write_data, p0_read, p0_write, p0_user,
        output p0_read_data, p0_ack, p0_nxm,
        input  p1_addr, p1_write_data, p1_read, p1_write, p1_user,
        output p1_read_data, p1_ack, p1_nxm,
        output mem_addr, mem_write_data, mem_read, mem_write, mem_user,
        input  mem_read_data, mem_ack
    );

    modport master (
        output p0_addr, p0_write_data, p0_read, p0_write, p0_user,
        input  p0_read_data, p0_ack, p0_nxm,
        output p1_addr, p1_write_data, p1_read, p1_write, p1_user,
        input  p1_read_data, p1_ack, p1_nxm,
        input  mem_addr, mem_write_data, mem_read, mem_write, mem_user,
        output mem_read_data, mem_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous memory port between CPU (port 0) and I/O (port 1).
// Each transfer: latch winner, one-cycle strobe, wait for mem_ack or watchdog, one-cycle ack.
//
// state | meaning
// IDLE  | sample fresh requests, latch winner onto mem_*
// ISSUE | one-cycle mem_read / mem_write strobe, clear watchdog
// WAIT  | hold mem_*, wait for mem_ack or watchdog expiry (NXM)
// RESP  | one-cycle ack with read data / nxm to the winner
module mem_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 16,
    parameter int ADDR_W     = 18,
    parameter int WORD_W     = 36
) (
    input logic          clk,
    input logic          reset_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int            TW     = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [TW-1:0]     timer;
    logic              rr_ptr;
    logic              port;
    logic              op_rd;
    logic              nxm;
    logic [WORD_W-1:0] rdata;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              user_q;

    logic v0;
    logic v1;
    logic any_req;
    logic win1;
    logic win_rd;

    assign v0      = bus.p0_read | bus.p0_write;
    assign v1      = bus.p1_read | bus.p1_write;
    assign any_req = v0 | v1;
    // rr_ptr names the port favoured on the next tie; fixed priority ignores it
    assign win1    = v1 & (~v0 | (rr_ptr & (FIXED_PRIO == 0)));
    assign win_rd  = win1 ? bus.p1_read : bus.p0_read;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.mem_ack || timer == T_LAST) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer   <= '0;
            rr_ptr  <= 1'b0;
            port    <= 1'b0;
            op_rd   <= 1'b0;
            nxm     <= 1'b0;
            rdata   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            user_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        addr_q  <= win1 ? bus.p1_addr : bus.p0_addr;
                        wdata_q <= win1 ? bus.p1_write_data : bus.p0_write_data;
                        user_q  <= win1 ? bus.p1_user : bus.p0_user;
                        op_rd   <= win_rd;
                        port    <= win1;
                        rr_ptr  <= ~win1;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    nxm   <= 1'b0;
                    rdata <= '0;
                end
                WAIT: begin
                    if (bus.mem_ack) begin
                        rdata <= op_rd ? bus.mem_read_data : '0;
                    end else if (timer == T_LAST) begin
                        nxm   <= 1'b1;
                        rdata <= '0;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_addr       = addr_q;
        bus.mem_write_data = wdata_q;
        bus.mem_user       = user_q;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.p0_ack         = 1'b0;
        bus.p0_nxm         = 1'b0;
        bus.p0_read_data   = '0;
        bus.p1_ack         = 1'b0;
        bus.p1_nxm         = 1'b0;
        bus.p1_read_data   = '0;
        unique case (state)
            ISSUE: begin
                bus.mem_read  = op_rd;
                bus.mem_write = ~op_rd;
            end
            RESP: begin
                if (port) begin
                    bus.p1_ack       = 1'b1;
                    bus.p1_nxm       = nxm;
                    bus.p1_read_data = rdata;
                end else begin
                    bus.p0_ack       = 1'b1;
                    bus.p0_nxm       = nxm;
                    bus.p0_read_data = rdata;
                end
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, reset/timeout corners, arbitration order,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int AW  = 18;
    localparam int WW  = 36;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .WORD_W(WW)) b1 ();
    mem_arbiter_if #(.ADDR_W(AW), .WORD_W(WW)) b2 ();

    mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TMO), .ADDR_W(AW), .WORD_W(WW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(b1.slave));
    mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(TMO), .ADDR_W(AW), .WORD_W(WW)) dut_fp (
        .clk(clk), .reset_n(reset_n), .bus(b2.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // memory model for the round-robin instance
    logic [WW-1:0] ram [0:1023];
    bit            ram_init = 0;
    bit            pending  = 0;
    int            cnt      = 0;
    logic [AW-1:0] cap_a;
    logic [WW-1:0] cap_d;
    logic          cap_u;
    logic          cap_rd;
    bit            ack_en   = 1;
    bit            hold_chk = 1;
    bit            lat_rand = 0;
    int            lat      = 0;

    always @(negedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] = '0;
            ram[64]  = 36'o123456654321;
            ram_init = 1;
        end
        b1.mem_ack       = 1'b0;
        b1.mem_read_data = '0;
        if (pending) begin
            if (hold_chk) begin
                chk("mem_hold_addr", b1.mem_addr, cap_a);
                chk("mem_hold_data", b1.mem_write_data, cap_d);
                chk("mem_hold_user", b1.mem_user, cap_u);
            end
            if (cnt == 0) begin
                b1.mem_ack       = 1'b1;
                b1.mem_read_data = cap_rd ? ram[cap_a[9:0]] : '0;
                pending          = 0;
            end else begin
                cnt--;
            end
        end
        if (b1.mem_read === 1'b1 || b1.mem_write === 1'b1) begin
            chk("strobe_exclusive", b1.mem_read & b1.mem_write, 0);
            chk("one_outstanding", pending, 0);
            if (ack_en) begin
                pending = 1;
                cnt     = lat_rand ? int'($urandom_range(0, 3)) : lat;
                cap_a   = b1.mem_addr;
                cap_d   = b1.mem_write_data;
                cap_u   = b1.mem_user;
                cap_rd  = b1.mem_read;
                if (b1.mem_write) ram[b1.mem_addr[9:0]] = b1.mem_write_data;
            end
        end
    end

    // zero-wait memory for the fixed-priority instance
    bit pend2 = 0;
    always @(negedge clk) begin
        b2.mem_ack       = pend2;
        b2.mem_read_data = '0;
        pend2            = (b2.mem_read === 1'b1) || (b2.mem_write === 1'b1);
    end

    task automatic drive_req(input bit port, input bit rd, input bit wr,
                             input logic [AW-1:0] a, input logic [WW-1:0] d, input bit u);
        if (port) begin
            b1.p1_read = rd; b1.p1_write = wr; b1.p1_addr = a; b1.p1_write_data = d; b1.p1_user = u;
        end else begin
            b1.p0_read = rd; b1.p0_write = wr; b1.p0_addr = a; b1.p0_write_data = d; b1.p0_user = u;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // one transfer on the round-robin instance; called at a negedge with the arbiter idle
    task automatic xfer(input bit port, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [WW-1:0] d, input bit u,
                        output logic [WW-1:0] rdat, output bit nx, output int ack_at,
                        output int n_rs, output int n_ws, output bit other);
        rdat = '0; nx = 0; ack_at = -1; n_rs = 0; n_ws = 0; other = 0;
        drive_req(port, rd, wr, a, d, u);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (b1.mem_read || b1.mem_write) begin
                if (n_rs + n_ws == 0) begin
                    chk("strobe_addr", b1.mem_addr, a);
                    chk("strobe_user", b1.mem_user, u);
                    chk("strobe_wdata", b1.mem_write_data, d);
                end
                if (b1.mem_read) n_rs++;
                if (b1.mem_write) n_ws++;
            end
            if (port ? b1.p0_ack : b1.p1_ack) other = 1;
            if (port ? b1.p1_ack : b1.p0_ack) begin
                rdat   = port ? b1.p1_read_data : b1.p0_read_data;
                nx     = port ? b1.p1_nxm : b1.p0_nxm;
                ack_at = k;
                break;
            end
        end
        drive_req(port, 0, 0, a, d, u);
    endtask

    typedef struct packed {
        bit            port;
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
        bit            user;
        int            lat;
        bit            noack;
        logic [WW-1:0] exp_rdata;
        bit            exp_nxm;
        int            exp_ack;
        int            exp_rs;
        int            exp_ws;
    } vec_t;

    vec_t          vt [11];
    logic [WW-1:0] rdat;
    bit            nx;
    bit            other;
    int            ack_at, n_rs, n_ws, n_ack, n_str;
    int            n1, n2;
    bit            g1 [4];
    bit            g2 [4];

    // reference-model state for the random phase
    logic [WW-1:0] shadow [0:1023];
    bit            pend [2];
    bit            seen [2];
    bit            m_rdb [2];
    bit            m_wrb [2];
    logic [AW-1:0] m_a [2];
    logic [WW-1:0] m_d [2];
    bit            m_u [2];
    int            gap [2];
    int            favor, inflight, age, done_n, w_s, w_a, op;
    logic [WW-1:0] m_exp;
    bit            acked [2];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.p0_read = 0; b1.p0_write = 0; b1.p0_addr = '0; b1.p0_write_data = '0; b1.p0_user = 0;
        b1.p1_read = 0; b1.p1_write = 0; b1.p1_addr = '0; b1.p1_write_data = '0; b1.p1_user = 0;
        b2.p0_read = 0; b2.p0_write = 0; b2.p0_addr = '0; b2.p0_write_data = '0; b2.p0_user = 0;
        b2.p1_read = 0; b2.p1_write = 0; b2.p1_addr = '0; b2.p1_write_data = '0; b2.p1_user = 0;

        //         port rd wr addr      wdata         user lat noack exp_rdata              nxm ack rs ws
        vt[0]  = '{1'b0, 1'b1, 1'b0, 18'o100, 36'o0,   1'b0, 0, 1'b0, 36'o123456654321, 1'b0, 3,  1, 0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 18'o200, 36'o777, 1'b1, 3, 1'b0, 36'o0,            1'b0, 6,  0, 1};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 18'o200, 36'o0,   1'b0, 0, 1'b0, 36'o777,          1'b0, 3,  1, 0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 18'o300, 36'o111, 1'b0, 1, 1'b0, 36'o0,            1'b0, 4,  0, 1};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 18'o300, 36'o0,   1'b1, 2, 1'b0, 36'o111,          1'b0, 5,  1, 0};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 18'o200, 36'o555, 1'b0, 0, 1'b0, 36'o777,          1'b0, 3,  1, 0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 18'o200, 36'o0,   1'b0, 0, 1'b0, 36'o777,          1'b0, 3,  1, 0};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 18'o100, 36'o0,   1'b0, 0, 1'b1, 36'o0,            1'b1, 18, 1, 0};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 18'o100, 36'o0,   1'b0, 0, 1'b0, 36'o123456654321, 1'b0, 3,  1, 0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 18'o400, 36'o42,  1'b0, 0, 1'b1, 36'o0,            1'b1, 18, 0, 1};
        vt[10] = '{1'b0, 1'b1, 1'b0, 18'o400, 36'o0,   1'b1, 0, 1'b0, 36'o0,            1'b0, 3,  1, 0};

        // reset held with a pending request: everything quiet
        b1.p0_read = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_ctl", {b1.mem_read, b1.mem_write, b1.mem_user, b1.p0_ack, b1.p1_ack,
                            b1.p0_nxm, b1.p1_nxm}, 0);
            chk("rst_addr", b1.mem_addr, 0);
            chk("rst_wdata", b1.mem_write_data, 0);
            chk("rst_rdata", b1.p0_read_data | b1.p1_read_data, 0);
        end
        b1.p0_read = 0;
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            ack_en = !vt[i].noack;
            lat    = vt[i].lat;
            xfer(vt[i].port, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].user,
                 rdat, nx, ack_at, n_rs, n_ws, other);
            chk($sformatf("vec%0d_rdata", i), rdat, vt[i].exp_rdata);
            chk($sformatf("vec%0d_nxm", i), nx, vt[i].exp_nxm);
            chk($sformatf("vec%0d_ack_cycle", i), ack_at, vt[i].exp_ack);
            chk($sformatf("vec%0d_read_strobes", i), n_rs, vt[i].exp_rs);
            chk($sformatf("vec%0d_write_strobes", i), n_ws, vt[i].exp_ws);
            chk($sformatf("vec%0d_other_ack", i), other, 0);
            @(negedge clk);
        end
        ack_en = 1;
        lat    = 0;

        // reset during WAIT; the late mem_ack must not produce an ack
        hold_chk = 0;
        lat      = 5;
        drive_req(0, 1, 0, 18'o100, '0, 0);
        @(negedge clk);
        chk("rst_wait_strobe", b1.mem_read, 1);
        @(negedge clk);
        reset_n = 1'b0;
        drive_req(0, 0, 0, 18'o100, '0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        n_ack = 0;
        n_str = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b1.p0_ack || b1.p1_ack) n_ack++;
            if (b1.mem_read || b1.mem_write) n_str++;
        end
        chk("rst_wait_no_ack", n_ack, 0);
        chk("rst_wait_no_strobe", n_str, 0);
        hold_chk = 1;
        lat      = 0;
        xfer(1, 1, 0, 18'o200, '0, 0, rdat, nx, ack_at, n_rs, n_ws, other);
        chk("after_rst_rdata", rdat, 36'o777);
        chk("after_rst_ack_cycle", ack_at, 3);
        @(negedge clk);

        // both ports held on both instances
        reset_pulse();
        b1.p0_addr = 18'o100; b1.p1_addr = 18'o200; b1.p0_read = 1; b1.p1_read = 1;
        b2.p0_addr = 18'o100; b2.p1_addr = 18'o200; b2.p0_read = 1; b2.p1_read = 1;
        n1 = 0;
        n2 = 0;
        for (int k = 0; k < 40 && (n1 < 4 || n2 < 4); k++) begin
            @(negedge clk);
            if ((b1.p0_ack || b1.p1_ack) && n1 < 4) begin g1[n1] = b1.p1_ack; n1++; end
            if ((b2.p0_ack || b2.p1_ack) && n2 < 4) begin g2[n2] = b2.p1_ack; n2++; end
        end
        b1.p0_read = 0; b1.p1_read = 0; b2.p0_read = 0; b2.p1_read = 0;
        chk("rr_grant_count", n1, 4);
        chk("fp_grant_count", n2, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), g1[i], i % 2);
            chk($sformatf("fp_grant%0d", i), g2[i], 0);
        end
        @(negedge clk);
        @(negedge clk);

        // randomized traffic vs. transaction-level model
        reset_pulse();
        for (int i = 0; i < 1024; i++) shadow[i] = ram[i];
        lat_rand = 1;
        favor    = 0;
        inflight = -1;
        age      = 0;
        done_n   = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; seen[p] = 0; gap[p] = 0; m_rdb[p] = 0; m_wrb[p] = 0;
            m_a[p] = '0; m_d[p] = '0; m_u[p] = 0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            acked[0] = 0;
            acked[1] = 0;
            if (b1.mem_read || b1.mem_write) begin
                w_s = (seen[0] && seen[1]) ? favor : (seen[1] ? 1 : 0);
                chk("rand_req_present", seen[0] | seen[1], 1);
                chk("rand_idle_strobe", inflight == -1, 1);
                chk("rand_addr", b1.mem_addr, m_a[w_s]);
                chk("rand_op_read", b1.mem_read, m_rdb[w_s]);
                chk("rand_user", b1.mem_user, m_u[w_s]);
                if (!m_rdb[w_s]) begin
                    chk("rand_wdata", b1.mem_write_data, m_d[w_s]);
                    shadow[m_a[w_s][9:0]] = m_d[w_s];
                end
                m_exp    = m_rdb[w_s] ? shadow[m_a[w_s][9:0]] : '0;
                favor    = 1 - w_s;
                inflight = w_s;
                age      = 0;
            end else if (inflight >= 0) begin
                age++;
                if (age == 12) chk("rand_stall_age", age, 0);
            end
            if (b1.p0_ack || b1.p1_ack) begin
                w_a = b1.p1_ack ? 1 : 0;
                chk("rand_single_ack", b1.p0_ack & b1.p1_ack, 0);
                chk("rand_ack_port", w_a, inflight);
                chk("rand_rdata", w_a ? b1.p1_read_data : b1.p0_read_data, m_exp);
                chk("rand_nxm", b1.p0_nxm | b1.p1_nxm, 0);
                inflight   = -1;
                pend[w_a]  = 0;
                acked[w_a] = 1;
                gap[w_a]   = $urandom_range(0, 3);
                done_n++;
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && !acked[p]) begin
                    if (gap[p] > 0) begin
                        gap[p]--;
                    end else if ($urandom_range(0, 1) == 1) begin
                        op       = $urandom_range(0, 2);
                        m_rdb[p] = (op != 1);
                        m_wrb[p] = (op != 0);
                        m_a[p]   = AW'($urandom_range(0, 15));
                        m_d[p]   = {4'h0, $urandom};
                        m_u[p]   = $urandom_range(0, 1);
                        pend[p]  = 1;
                    end
                end
                drive_req(p[0], pend[p] & m_rdb[p], pend[p] & m_wrb[p], m_a[p], m_d[p], m_u[p]);
                seen[p] = pend[p];
            end
        end
        chk("rand_progress", done_n >= 200, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
